// File: rtl/quad_loader_pkg.sv
// Shared constants for the quad loader: data width default, group size
// and the fill-count encoding.
package quad_loader_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int SLOTS     = 4;
  localparam int CNT_W     = 3;
  localparam int IDX_W     = 2;

  // Fill count value meaning "all slots occupied".
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

endpackage

// File: rtl/quad_loader_if.sv
// Serial-in / four-wide-out bus of the quad loader.
// The slave side is the loader itself; the master side is the environment.
interface quad_loader_if
  import quad_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic             padded;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, a, b, c, d, out_valid, padded
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, a, b, c, d, out_valid, padded
  );

endinterface

// File: rtl/quad_out_reg.sv
// Output holding register for one four-value group. Accepts a new group
// whenever it is empty or being drained on the same edge, and otherwise
// holds its contents stable.
module quad_out_reg
  import quad_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data [SLOTS],
  input  logic             load_pad,
  input  logic             out_ready,
  output logic             can_load,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             padded
);

  logic [WIDTH-1:0] hold_reg [SLOTS];
  logic             valid_reg;
  logic             pad_reg;
  logic             load_en;

  // Room exists if nothing is held or the held group leaves this edge.
  assign can_load = !valid_reg || out_ready;
  assign load_en  = load_valid && can_load;

  // Group data: captured on load, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) hold_reg[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < SLOTS; i++) hold_reg[i] <= load_data[i];
    end
  end

  // Valid / padded flags: set by a load, cleared by a drain without reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pad_reg   <= 1'b0;
    end else if (load_en) begin
      valid_reg <= 1'b1;
      pad_reg   <= load_pad;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
      pad_reg   <= 1'b0;
    end
  end

  assign a         = hold_reg[0];
  assign b         = hold_reg[1];
  assign c         = hold_reg[2];
  assign d         = hold_reg[3];
  assign out_valid = valid_reg;
  assign padded    = pad_reg;

endmodule

// File: rtl/quad_loader.sv
// Collects a serial stream into groups of four for a downstream min/max
// stage. A partial group can be closed early with flush; empty slots are
// then filled with the last accepted value so min/max is unaffected.
// A completed group that cannot enter the output register waits in the
// fill buffer (count held at 4, which deasserts in_ready).
module quad_loader
  import quad_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  quad_loader_if.slave bus
);

  logic [WIDTH-1:0] slot_reg  [SLOTS];
  logic [WIDTH-1:0] slot_next [SLOTS];
  logic [WIDTH-1:0] fill_w    [SLOTS];
  logic [WIDTH-1:0] grp_w     [SLOTS];
  logic [WIDTH-1:0] load_data [SLOTS];
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] eff_cnt;
  logic [IDX_W-1:0] last_idx;
  logic [WIDTH-1:0] last_val;
  logic             pend_pad_reg;
  logic             pend_pad_next;
  logic             rdy_reg;
  logic             accept;
  logic             pending;
  logic             flush_hit;
  logic             complete;
  logic             grp_pad;
  logic             can_load;
  logic             load_valid;
  logic             load_pad;

  // Acceptance, effective fill (including this cycle's value) and completion.
  always_comb begin
    accept    = bus.in_valid && rdy_reg;
    eff_cnt   = cnt_reg + {{(CNT_W-1){1'b0}}, accept};
    pending   = (cnt_reg == CNT_FULL);
    flush_hit = bus.flush && rdy_reg && (eff_cnt != '0) && (eff_cnt != CNT_FULL);
    complete  = !pending && ((eff_cnt == CNT_FULL) || flush_hit);
    grp_pad   = (eff_cnt != CNT_FULL);
    fill_w    = slot_reg;
    if (accept) fill_w[cnt_reg[IDX_W-1:0]] = bus.in_data;
    last_idx  = IDX_W'(eff_cnt - CNT_W'(1));
    last_val  = fill_w[last_idx];
  end

  // Padded view of the group: slots beyond the fill repeat the last value.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pad
      assign grp_w[gi] = (CNT_W'(gi) < eff_cnt) ? fill_w[gi] : last_val;
    end
  endgenerate

  // Next fill state and what is offered to the output register.
  always_comb begin
    slot_next     = fill_w;
    cnt_next      = eff_cnt;
    pend_pad_next = pend_pad_reg;
    load_valid    = pending || complete;
    load_pad      = pending ? pend_pad_reg : grp_pad;
    for (int i = 0; i < SLOTS; i++) begin
      load_data[i] = pending ? slot_reg[i] : grp_w[i];
    end
    if (pending) begin
      if (can_load) cnt_next = '0;
    end else if (complete) begin
      if (can_load) begin
        cnt_next = '0;
      end else begin
        slot_next     = grp_w;
        cnt_next      = CNT_FULL;
        pend_pad_next = grp_pad;
      end
    end
  end

  // Fill buffer, count and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_reg[i] <= '0;
      cnt_reg      <= '0;
      pend_pad_reg <= 1'b0;
      rdy_reg      <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) slot_reg[i] <= slot_next[i];
      cnt_reg      <= cnt_next;
      pend_pad_reg <= pend_pad_next;
      rdy_reg      <= (cnt_next != CNT_FULL);
    end
  end

  assign bus.in_ready = rdy_reg;

  quad_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_pad   (load_pad),
    .out_ready  (bus.out_ready),
    .can_load   (can_load),
    .a          (bus.a),
    .b          (bus.b),
    .c          (bus.c),
    .d          (bus.d),
    .out_valid  (bus.out_valid),
    .padded     (bus.padded)
  );

endmodule

// File: tb/tb_quad_loader.sv
// Directed bench for quad_loader with a group-level scoreboard.
module tb_quad_loader;
  import quad_loader_pkg::*;

  localparam int W = 5;

  typedef struct packed {
    logic         pad;
    logic [W-1:0] d;
    logic [W-1:0] c;
    logic [W-1:0] b;
    logic [W-1:0] a;
  } grp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   groups_seen = 0;

  always #5 clk = ~clk;

  quad_loader_if #(.WIDTH(W)) bus ();

  quad_loader #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- model: groups completed but not yet consumed ----------
  grp_t         exp_q[$];
  logic [W-1:0] part[$];
  bit           post_rst = 1'b0;

  function automatic grp_t out_now();
    grp_t g;
    g.pad = bus.padded; g.a = bus.a; g.b = bus.b; g.c = bus.c; g.d = bus.d;
    return g;
  endfunction

  // Compare at every falling edge, then advance the model by the
  // handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    int   exp_rdy;
    int   exp_ov;
    int   n;
    grp_t g;
    if (rst) begin
      exp_q.delete();
      part.delete();
      post_rst = 1'b1;
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_outputs", int'(out_now()), 0);
    end else begin
      exp_rdy = (!post_rst && exp_q.size() < 2) ? 1 : 0;
      exp_ov  = (exp_q.size() > 0) ? 1 : 0;
      chk("in_ready", int'(bus.in_ready), exp_rdy);
      chk("out_valid", int'(bus.out_valid), exp_ov);
      if (exp_ov == 1) chk("group", int'(out_now()), int'(exp_q[0]));
      if (exp_ov == 1 && bus.out_ready) begin
        $display("out group a=%0d b=%0d c=%0d d=%0d padded=%0d",
                 bus.a, bus.b, bus.c, bus.d, bus.padded);
        void'(exp_q.pop_front());
        groups_seen++;
      end
      if (bus.in_valid && exp_rdy == 1) part.push_back(bus.in_data);
      n = part.size();
      if (n == 4 || (n > 0 && bus.flush && exp_rdy == 1)) begin
        g.a   = part[0];
        g.b   = (n > 1) ? part[1] : part[n-1];
        g.c   = (n > 2) ? part[2] : part[n-1];
        g.d   = (n > 3) ? part[3] : part[n-1];
        g.pad = (n < 4);
        exp_q.push_back(g);
        part.delete();
      end
      post_rst = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input bit fl);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(v);
    bus.flush    = fl;
    cyc();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic chk_out(input string name, input int ea, input int eb,
                         input int ec, input int ed, input int ep);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_a"}, int'(bus.a), ea);
    chk({name, "_b"}, int'(bus.b), eb);
    chk({name, "_c"}, int'(bus.c), ec);
    chk({name, "_d"}, int'(bus.d), ed);
    chk({name, "_padded"}, int'(bus.padded), ep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int mn;
    int mx;
    int g0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_out", int'(out_now()), 0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", int'(bus.in_ready), 1);

    // Plain group, min/max of the delivered values.
    bus.out_ready = 1'b1;
    push(3, 0); push(17, 0); push(9, 0); push(30, 0);
    chk_out("grp3", 3, 17, 9, 30, 0);
    mn = int'(bus.a); mx = int'(bus.a);
    if (int'(bus.b) < mn) mn = int'(bus.b); if (int'(bus.b) > mx) mx = int'(bus.b);
    if (int'(bus.c) < mn) mn = int'(bus.c); if (int'(bus.c) > mx) mx = int'(bus.c);
    if (int'(bus.d) < mn) mn = int'(bus.d); if (int'(bus.d) > mx) mx = int'(bus.d);
    chk("min", mn, 3);
    chk("max", mx, 30);
    cyc();
    chk("drained", int'(bus.out_valid), 0);

    // Flush after two values, then flush on an empty buffer.
    push(5, 0); push(12, 0);
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    chk_out("flush2", 5, 12, 12, 12, 1);
    cyc();
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    chk("empty_flush", int'(bus.out_valid), 0);
    cyc();
    chk("empty_flush2", int'(bus.out_valid), 0);

    // Single value closed by a flush in the same cycle.
    push(9, 1);
    chk_out("flush1", 9, 9, 9, 9, 1);
    cyc();

    // Fourth value and flush together: not padded.
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    chk_out("full_flush", 1, 2, 3, 4, 0);
    cyc();

    // Back-pressure: second group waits in the fill buffer.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(i, 0);
    chk_out("held", 1, 2, 3, 4, 0);
    chk("held_in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
    chk_out("moved", 5, 6, 7, 8, 0);
    chk("moved_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1; cyc();
    chk("moved_drained", int'(bus.out_valid), 0);

    // Continuous streaming: one group every four cycles.
    g0 = groups_seen;
    for (int i = 0; i < 12; i++) begin
      push(10 + i, 0);
      chk("stream_pulse", int'(bus.out_valid), (i % 4 == 3) ? 1 : 0);
    end
    cyc();
    chk("stream_groups", groups_seen - g0, 3);

    // Reset in the middle of a held group and a partial group.
    bus.out_ready = 1'b0;
    push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    push(20, 0); push(21, 0);
    rst = 1'b1;
    #1;
    chk("async_out_valid", int'(bus.out_valid), 0);
    chk("async_in_ready", int'(bus.in_ready), 0);
    cyc(); cyc();
    rst = 1'b0;
    chk("release_in_ready", int'(bus.in_ready), 0);
    cyc();
    chk("release_in_ready2", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    push(7, 0); push(7, 0); push(0, 0); push(31, 0);
    chk_out("after_rst", 7, 7, 0, 31, 0);
    cyc(); cyc();
    chk("final_empty", int'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
